actor_move_ctrl: RTL and testbench

- Per-actor movement sequencer for the maze. Owns the registered pixel position and current heading of one actor (Pac-Man by default).
- Drives pos_x/pos_y into the combinational maze-lookup block and consumes its 4-bit available-direction vector.
- Steps the actor one pixel per earned speed step, buffers joystick pre-turns, stops at walls, and handles the row-14 side-tunnel wrap that the lookup cannot index.

---
 rtl/actor_move_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_actor_move_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/actor_move_ctrl.sv
// actor_move_ctrl: pixel position and heading sequencer for one maze actor.
// Steps on speed-accumulator carries, buffers pre-turns, wraps the side tunnel.
module actor_move_ctrl #(
  parameter int unsigned START_X   = 228,
  parameter int unsigned START_Y   = 336,
  parameter int unsigned BUF_TICKS = 16,
  parameter int unsigned TUNNEL_Y  = 228,
  parameter int unsigned X_LO      = 66,
  parameter int unsigned X_HI      = 390,
  parameter int unsigned WRAP_LO   = 54,
  parameter int unsigned WRAP_HI   = 402
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       move_tick,
  input  logic [7:0] speed,
  input  logic       start,
  input  logic       freeze,
  input  logic       respawn,
  input  logic [3:0] req_dir,
  input  logic [3:0] avail_dir,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [3:0] cur_dir,
  output logic       moving,
  output logic       wrapped
);

  localparam int unsigned CW = $clog2(BUF_TICKS + 1);

  localparam logic [9:0]    SX = 10'(START_X);
  localparam logic [9:0]    SY = 10'(START_Y);
  localparam logic [9:0]    TY = 10'(TUNNEL_Y);
  localparam logic [9:0]    XL = 10'(X_LO);
  localparam logic [9:0]    XH = 10'(X_HI);
  localparam logic [9:0]    WL = 10'(WRAP_LO);
  localparam logic [9:0]    WH = 10'(WRAP_HI);
  localparam logic [CW-1:0] BT = CW'(BUF_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVING,
    S_STOPPED,
    S_FROZEN
  } state_e;

  state_e state_q, state_d;

  logic [9:0]    pos_x_q, pos_x_d;
  logic [9:0]    pos_y_q, pos_y_d;
  logic [3:0]    cur_dir_q, cur_dir_d;
  logic [7:0]    acc_q, acc_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    pend_dir_q, pend_dir_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic          moving_q, moving_d;
  logic          wrapped_q, wrapped_d;

  logic          active;
  logic          acc_en;
  logic [8:0]    sum;
  logic          opp;
  logic          req_1h;
  logic          in_tun;
  logic          pend_hit;
  logic          cur_hit;
  logic          take_pend;
  logic          go;
  logic [3:0]    step_dir;
  logic [9:0]    nx;
  logic [9:0]    ny;
  logic          wrap;
  logic [CW-1:0] cnt_inc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    active   = (state_q == S_MOVING) || (state_q == S_STOPPED);
    acc_en   = active && !freeze && move_tick;
    sum      = {1'b0, acc_q} + {1'b0, speed};
    opp      = acc_en && sum[8];
    req_1h   = (|req_dir) && ((req_dir & (req_dir - 4'd1)) == 4'd0);
    cnt_inc  = pend_cnt_q + 1'b1;
    in_tun   = (pos_y_q == TY) &&
               ((pos_x_q < XL) || (pos_x_q > XH) ||
                ((pos_x_q == XL) && cur_dir_q[0]) ||
                ((pos_x_q == XH) && cur_dir_q[2]));
    pend_hit = pend_vld_q && |(avail_dir & pend_dir_q);
    cur_hit  = |(avail_dir & cur_dir_q);

    // The lookup index is invalid inside the tunnel, so avail_dir is ignored there.
    take_pend = 1'b0;
    go        = 1'b0;
    unique case (1'b1)
      in_tun: begin
        take_pend = pend_vld_q && (pend_dir_q[0] | pend_dir_q[2]);
        go        = 1'b1;
      end
      !in_tun && pend_hit: begin
        take_pend = 1'b1;
        go        = 1'b1;
      end
      !in_tun && !pend_hit && cur_hit: begin
        go = 1'b1;
      end
      default: ;
    endcase
    step_dir = take_pend ? pend_dir_q : cur_dir_q;

    nx   = pos_x_q;
    ny   = pos_y_q;
    wrap = 1'b0;
    unique case (1'b1)
      step_dir[0]: begin
        if (in_tun && (pos_x_q == WL)) begin
          nx   = WH;
          wrap = 1'b1;
        end else begin
          nx = pos_x_q - 10'd1;
        end
      end
      step_dir[1]: ny = pos_y_q - 10'd1;
      step_dir[2]: begin
        if (in_tun && (pos_x_q == WH)) begin
          nx   = WL;
          wrap = 1'b1;
        end else begin
          nx = pos_x_q + 10'd1;
        end
      end
      step_dir[3]: ny = pos_y_q + 10'd1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (respawn) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !freeze) state_d = S_MOVING;
        end
        S_MOVING, S_STOPPED: begin
          if (freeze) begin
            state_d = S_FROZEN;
          end else if (opp) begin
            state_d = go ? S_MOVING : S_STOPPED;
          end
        end
        S_FROZEN: begin
          if (!freeze) state_d = S_STOPPED;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    cur_dir_d  = cur_dir_q;
    acc_d      = acc_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    pend_cnt_d = pend_cnt_q;
    wrapped_d  = 1'b0;
    moving_d   = (state_d == S_MOVING);
    if (respawn) begin
      pos_x_d    = SX;
      pos_y_d    = SY;
      cur_dir_d  = 4'b0001;
      acc_d      = '0;
      pend_vld_d = 1'b0;
      pend_dir_d = '0;
      pend_cnt_d = '0;
    end else begin
      if (acc_en) acc_d = sum[7:0];
      if (opp && go) begin
        pos_x_d   = nx;
        pos_y_d   = ny;
        cur_dir_d = step_dir;
        wrapped_d = wrap;
      end
      if (move_tick && pend_vld_q) begin
        pend_cnt_d = cnt_inc;
        if (cnt_inc == BT) pend_vld_d = 1'b0;
      end
      if (opp && take_pend) pend_vld_d = 1'b0;
      // A fresh request wins over a same-cycle consumption.
      if (req_1h) begin
        pend_vld_d = 1'b1;
        pend_dir_d = req_dir;
        pend_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_q    <= SX;
      pos_y_q    <= SY;
      cur_dir_q  <= 4'b0001;
      acc_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= '0;
      pend_cnt_q <= '0;
      moving_q   <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      cur_dir_q  <= cur_dir_d;
      acc_q      <= acc_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      pend_cnt_q <= pend_cnt_d;
      moving_q   <= moving_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign cur_dir = cur_dir_q;
  assign moving  = moving_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_actor_move_ctrl.sv
// tb_actor_move_ctrl: directed and random scenarios for actor_move_ctrl
// against a behavioural position/heading model.
module tb_actor_move_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       move_tick = 1'b0;
  logic [7:0] speed = 8'd0;
  logic       start = 1'b0;
  logic       freeze = 1'b0;
  logic       respawn = 1'b0;
  logic [3:0] req_dir = 4'd0;
  logic [3:0] avail_dir = 4'd0;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [3:0] cur_dir;
  logic       moving;
  logic       wrapped;

  logic [25:0] obs;
  assign obs = {pos_x, pos_y, cur_dir, moving, wrapped};

  int n_chk = 0;
  int n_pass = 0;

  actor_move_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .move_tick (move_tick),
    .speed     (speed),
    .start     (start),
    .freeze    (freeze),
    .respawn   (respawn),
    .req_dir   (req_dir),
    .avail_dir (avail_dir),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .cur_dir   (cur_dir),
    .moving    (moving),
    .wrapped   (wrapped)
  );

  always #5 Clk = ~Clk;

  // Model: direction index 0..3 = left, up, right, down
  localparam int DX [4] = '{-1, 0, 1, 0};
  localparam int DY [4] = '{0, -1, 0, 1};
  localparam int M_IDLE = 0;
  localparam int M_MOV  = 1;
  localparam int M_STOP = 2;
  localparam int M_FRZ  = 3;

  int mx, my, mdir, mmode, macc, page, pidx;
  bit pvalid, mwrap;

  task automatic model_reset();
    mx = 228; my = 336; mdir = 0; mmode = M_IDLE; macc = 0;
    pvalid = 0; page = 0; pidx = 0; mwrap = 0;
  endtask

  function automatic int onehot_idx(logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [25:0] exp_vec();
    return {10'(mx), 10'(my), 4'(1 << mdir), mmode == M_MOV, mwrap};
  endfunction

  task automatic model_edge();
    int ridx;
    bit opp, tun, take, go;
    if (!Reset_n || respawn) begin
      model_reset();
      return;
    end
    mwrap = 0; opp = 0; take = 0; go = 0;
    ridx = onehot_idx(req_dir);
    tun = (my == 228) && (mx < 66 || mx > 390 ||
          (mx == 66 && mdir == 0) || (mx == 390 && mdir == 2));
    if ((mmode == M_MOV || mmode == M_STOP) && !freeze && move_tick) begin
      macc = macc + int'(speed);
      opp  = (macc >= 256);
      macc = macc % 256;
    end
    if (opp) begin
      if (tun) begin
        take = pvalid && (pidx % 2 == 0);
        go   = 1;
      end else if (pvalid && avail_dir[pidx]) begin
        take = 1;
        go   = 1;
      end else begin
        go = avail_dir[mdir];
      end
      if (take) mdir = pidx;
      if (go) begin
        if (tun && mdir == 0 && mx == 54) begin
          mx = 402; mwrap = 1;
        end else if (tun && mdir == 2 && mx == 402) begin
          mx = 54; mwrap = 1;
        end else begin
          mx += DX[mdir];
          my += DY[mdir];
        end
      end
    end
    case (mmode)
      M_IDLE: if (start && !freeze) mmode = M_MOV;
      M_MOV, M_STOP: begin
        if (freeze) mmode = M_FRZ;
        else if (opp) mmode = go ? M_MOV : M_STOP;
      end
      default: if (!freeze) mmode = M_STOP;
    endcase
    if (pvalid && move_tick) begin
      page++;
      if (page == 16) pvalid = 0;
    end
    if (take) pvalid = 0;
    if (ridx >= 0) begin
      pvalid = 1; pidx = ridx; page = 0;
    end
  endtask

  task automatic step_clk();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_tick();
    move_tick = 1'b1;
    step_clk();
    move_tick = 1'b0;
    step_clk();
  endtask

  task automatic test_reset();
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (obs !== {10'd228, 10'd336, 4'b0001, 1'b0, 1'b0})
      $display("FAIL reset_state got %h exp %h", obs,
               {10'd228, 10'd336, 4'b0001, 1'b0, 1'b0});
    else n_pass++;
    repeat (2) step_clk();
    Reset_n = 1'b1;
    step_clk();
    n_chk++;
    if (obs !== exp_vec())
      $display("FAIL reset_release got %h exp %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_start_move();
    speed = 8'h80; avail_dir = 4'b0001; start = 1'b1;
    step_clk();
    start = 1'b0;
    n_chk++;
    if (moving !== 1'b1 || obs !== exp_vec())
      $display("FAIL start_moving got %h exp %h", obs, exp_vec());
    else n_pass++;
    repeat (2) pulse_tick();
    n_chk++;
    if (pos_x !== 10'd227 || obs !== exp_vec())
      $display("FAIL step_tick2 got x=%0d exp x=227", pos_x);
    else n_pass++;
    repeat (2) pulse_tick();
    n_chk++;
    if ({pos_x, moving} !== {10'd226, 1'b1} || obs !== exp_vec())
      $display("FAIL step_tick4 got x=%0d mv=%b exp x=226 mv=1", pos_x, moving);
    else n_pass++;
  endtask

  task automatic test_preturn();
    req_dir = 4'b0010;
    step_clk();
    req_dir = 4'b0000;
    repeat (3) pulse_tick();
    n_chk++;
    if (obs !== exp_vec())
      $display("FAIL preturn_wait got %h exp %h", obs, exp_vec());
    else n_pass++;
    avail_dir = 4'b0011;
    pulse_tick();
    n_chk++;
    if ({cur_dir, pos_y, pos_x} !== {4'b0010, 10'd335, 10'd225} || obs !== exp_vec())
      $display("FAIL preturn_take got dir=%b y=%0d x=%0d exp dir=0010 y=335 x=225",
               cur_dir, pos_y, pos_x);
    else n_pass++;
  endtask

  task automatic test_expiry();
    req_dir = 4'b0001; avail_dir = 4'b0001;
    step_clk();
    req_dir = 4'b0000;
    repeat (2) pulse_tick();
    n_chk++;
    if (cur_dir !== 4'b0001 || obs !== exp_vec())
      $display("FAIL turn_left got %h exp %h", obs, exp_vec());
    else n_pass++;
    req_dir = 4'b1000;
    step_clk();
    req_dir = 4'b0000;
    repeat (16) pulse_tick();
    avail_dir = 4'b1001;
    repeat (2) pulse_tick();
    n_chk++;
    if ({cur_dir, pos_y} !== {4'b0001, 10'd335} || obs !== exp_vec())
      $display("FAIL preturn_expired got dir=%b y=%0d exp dir=0001 y=335",
               cur_dir, pos_y);
    else n_pass++;
  endtask

  task automatic test_wall();
    int ex;
    avail_dir = 4'b0000;
    repeat (2) pulse_tick();
    n_chk++;
    if (moving !== 1'b0 || obs !== exp_vec())
      $display("FAIL wall_stop got %h exp %h", obs, exp_vec());
    else n_pass++;
    ex = mx;
    req_dir = 4'b0100; avail_dir = 4'b0100;
    step_clk();
    req_dir = 4'b0000;
    repeat (2) pulse_tick();
    n_chk++;
    if ({pos_x, cur_dir, moving} !== {10'(ex + 1), 4'b0100, 1'b1} || obs !== exp_vec())
      $display("FAIL wall_resume got x=%0d dir=%b mv=%b exp x=%0d dir=0100 mv=1",
               pos_x, cur_dir, moving, ex + 1);
    else n_pass++;
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    step_clk();
    repeat (3) pulse_tick();
    n_chk++;
    if (moving !== 1'b0 || obs !== exp_vec())
      $display("FAIL frozen_hold got %h exp %h", obs, exp_vec());
    else n_pass++;
    freeze = 1'b0;
    step_clk();
    repeat (2) pulse_tick();
    n_chk++;
    if (moving !== 1'b1 || obs !== exp_vec())
      $display("FAIL unfreeze_resume got %h exp %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_tunnel();
    speed = 8'hFF;
    for (int i = 0; i < 2000 && !(my == 228 && mx == 55); i++) begin
      req_dir = (my > 228) ? 4'b0010 : 4'b0001;
      avail_dir = req_dir;
      move_tick = 1'b1;
      step_clk();
      move_tick = 1'b0;
      req_dir = 4'b0000;
    end
    n_chk++;
    if (obs !== {10'd55, 10'd228, 4'b0001, 1'b1, 1'b0})
      $display("FAIL tunnel_reach got %h exp %h", obs,
               {10'd55, 10'd228, 4'b0001, 1'b1, 1'b0});
    else n_pass++;
    avail_dir = 4'b0000;
    move_tick = 1'b1;
    for (int i = 0; i < 4 && mx != 54; i++) step_clk();
    n_chk++;
    if ({pos_x, wrapped} !== {10'd54, 1'b0} || obs !== exp_vec())
      $display("FAIL tunnel_54 got x=%0d w=%b exp x=54 w=0", pos_x, wrapped);
    else n_pass++;
    for (int i = 0; i < 4 && mx != 402; i++) step_clk();
    move_tick = 1'b0;
    n_chk++;
    if ({pos_x, wrapped} !== {10'd402, 1'b1} || obs !== exp_vec())
      $display("FAIL tunnel_wrap got x=%0d w=%b exp x=402 w=1", pos_x, wrapped);
    else n_pass++;
    step_clk();
    n_chk++;
    if ({pos_x, wrapped} !== {10'd402, 1'b0} || obs !== exp_vec())
      $display("FAIL wrap_pulse got x=%0d w=%b exp x=402 w=0", pos_x, wrapped);
    else n_pass++;
    move_tick = 1'b1;
    for (int i = 0; i < 4 && mx != 401; i++) step_clk();
    move_tick = 1'b0;
    n_chk++;
    if ({pos_x, cur_dir} !== {10'd401, 4'b0001} || obs !== exp_vec())
      $display("FAIL tunnel_401 got x=%0d dir=%b exp x=401 dir=0001", pos_x, cur_dir);
    else n_pass++;
    respawn = 1'b1;
    step_clk();
    respawn = 1'b0;
    repeat (3) pulse_tick();
    n_chk++;
    if (obs !== {10'd228, 10'd336, 4'b0001, 1'b0, 1'b0} || obs !== exp_vec())
      $display("FAIL respawn_idle got %h exp %h", obs,
               {10'd228, 10'd336, 4'b0001, 1'b0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    speed = 8'hFF; avail_dir = 4'b0001; start = 1'b1;
    step_clk();
    start = 1'b0;
    move_tick = 1'b1;
    repeat (4) step_clk();
    Reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (obs !== {10'd228, 10'd336, 4'b0001, 1'b0, 1'b0})
      $display("FAIL async_reset got %h exp %h", obs,
               {10'd228, 10'd336, 4'b0001, 1'b0, 1'b0});
    else n_pass++;
    step_clk();
    #2 Reset_n = 1'b1;
    repeat (3) step_clk();
    move_tick = 1'b0;
    n_chk++;
    if (obs !== {10'd228, 10'd336, 4'b0001, 1'b0, 1'b0} || obs !== exp_vec())
      $display("FAIL reset_idle got %h exp %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    int sp_tab [4] = '{0, 128, 255, 77};
    start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) speed = 8'(sp_tab[$urandom_range(0, 3)]);
      move_tick = 1'($urandom_range(0, 1));
      req_dir = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      avail_dir = 4'($urandom);
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      start = ($urandom_range(0, 19) == 0);
      respawn = ($urandom_range(0, 199) == 0);
      step_clk();
      n_chk++;
      if (obs !== exp_vec())
        $display("FAIL random_cyc%0d got %h exp %h", i, obs, exp_vec());
      else n_pass++;
    end
    move_tick = 1'b0; req_dir = 4'b0000; freeze = 1'b0;
    start = 1'b0; respawn = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_start_move();
    test_preturn();
    test_expiry();
    test_wall();
    test_freeze();
    test_tunnel();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
